// File: rtl/and_or_32bit.sv
// Bit-sliced bitwise AND/OR unit. It has a zero-latency combinational path and a
// registered copy of both results with a valid flag for pipelined consumers.
module and_or_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_and,
  output logic [WIDTH-1:0] out_or,
  output logic [WIDTH-1:0] q_and,
  output logic [WIDTH-1:0] q_or,
  output logic             q_valid
);

  logic [WIDTH-1:0] and_d, and_q;
  logic [WIDTH-1:0] or_d, or_q;
  logic             valid_d, valid_q;

  // One AND gate and one OR gate per bit. Each result bit depends only on its own input bits.
  for (genvar i = 0; i < WIDTH; i++) begin : g_slice
    assign out_and[i] = in_a[i] & in_b[i];
    assign out_or[i]  = in_a[i] | in_b[i];
  end

  always_comb begin
    and_d   = and_q;
    or_d    = or_q;
    valid_d = 1'b0;
    if (in_valid) begin
      and_d   = out_and;
      or_d    = out_or;
      valid_d = 1'b1;
    end
  end

  // Reset is synchronous and takes priority over in_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      and_q   <= '0;
      or_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      and_q   <= and_d;
      or_q    <= or_d;
      valid_q <= valid_d;
    end
  end

  assign q_and   = and_q;
  assign q_or    = or_q;
  assign q_valid = valid_q;

endmodule

// File: tb/tb_and_or_32bit.sv
// Directed bench for and_or_32bit. It covers the combinational sweep, the registered path,
// hold behaviour, back-to-back throughput and reset priority.
module tb_and_or_32bit;

  logic        clk;
  logic        reset;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic        in_valid;
  logic [31:0] out_and;
  logic [31:0] out_or;
  logic [31:0] q_and;
  logic [31:0] q_or;
  logic        q_valid;

  int tests_run;
  int tests_failed;

  and_or_32bit #(
    .WIDTH(32)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_valid(in_valid),
    .out_and (out_and),
    .out_or  (out_or),
    .q_and   (q_and),
    .q_or    (q_or),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic comb_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_and, input logic [31:0] exp_or);
    in_a = a;
    in_b = b;
    #1;
    chk({tag, "_and"}, out_and, exp_and);
    chk({tag, "_or"}, out_or, exp_or);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_q(input string tag, input logic [31:0] exp_and, input logic [31:0] exp_or,
                       input logic exp_valid);
    chk({tag, "_qand"}, q_and, exp_and);
    chk({tag, "_qor"}, q_or, exp_or);
    chk({tag, "_qvalid"}, {31'd0, q_valid}, {31'd0, exp_valid});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_a         = '0;
    in_b         = '0;

    // Combinational sweep. These checks need no clock edge.
    comb_vec("zero_zero", 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    comb_vec("ones_zero", 32'hffff_ffff, 32'h0000_0000, 32'h0000_0000, 32'hffff_ffff);
    comb_vec("zero_ones", 32'h0000_0000, 32'hffff_ffff, 32'h0000_0000, 32'hffff_ffff);
    comb_vec("alt_5a",    32'h5555_5555, 32'haaaa_aaaa, 32'h0000_0000, 32'hffff_ffff);
    comb_vec("alt_55",    32'h5555_5555, 32'h5555_5555, 32'h5555_5555, 32'h5555_5555);
    comb_vec("ones_ones", 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff);
    comb_vec("mixed",     32'h1234_5678, 32'h0f0f_0f0f, 32'h0204_0608, 32'h1f3f_5f7f);

    // Hold reset for 2 edges.
    in_a = '0;
    in_b = '0;
    step();
    step();
    chk_q("reset", 32'h0, 32'h0, 1'b0);

    // Single transaction with a 1-cycle latency.
    reset    = 1'b0;
    in_a     = 32'hf0f0_f0f0;
    in_b     = 32'hff00_ff00;
    in_valid = 1'b1;
    step();
    chk_q("single", 32'hf000_f000, 32'hfff0_fff0, 1'b1);

    // With in_valid low the results hold and valid drops, even when the operands change.
    in_valid = 1'b0;
    in_a     = 32'h0000_0000;
    in_b     = 32'h0000_0000;
    step();
    chk_q("hold", 32'hf000_f000, 32'hfff0_fff0, 1'b0);
    step();
    chk_q("hold2", 32'hf000_f000, 32'hfff0_fff0, 1'b0);

    // Back-to-back transactions, one result per cycle.
    in_valid = 1'b1;
    in_a     = 32'h1234_5678;
    in_b     = 32'h0f0f_0f0f;
    step();
    chk_q("b2b0", 32'h0204_0608, 32'h1f3f_5f7f, 1'b1);
    in_a = 32'hdead_beef;
    in_b = 32'h00ff_00ff;
    step();
    chk_q("b2b1", 32'h00ad_00ef, 32'hdeff_beff, 1'b1);
    in_a = 32'h8000_0001;
    in_b = 32'h0000_0001;
    step();
    chk_q("b2b2", 32'h0000_0001, 32'h8000_0001, 1'b1);

    // Reset takes priority over in_valid. The combinational outputs are unaffected.
    reset    = 1'b1;
    in_valid = 1'b1;
    in_a     = 32'hffff_ffff;
    in_b     = 32'hffff_ffff;
    #1;
    chk("prio_pre_and", out_and, 32'hffff_ffff);
    step();
    chk_q("prio", 32'h0, 32'h0, 1'b0);
    chk("prio_and", out_and, 32'hffff_ffff);
    chk("prio_or", out_or, 32'hffff_ffff);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
